// File: rtl/axi_id_mux.sv
// axi_id_mux: merges NoSlvPorts ID-prepended AXI slave ports onto one master port.
// Define AXI_MUX_SPILL_REG_EN to register mst_aw_*/mst_ar_* through a two-entry spill register.
module axi_id_mux_rr #(
    parameter int N    = 2,
    parameter int SelW = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    valid_i,
    input  logic            en_i,
    input  logic            ready_i,
    output logic            req_o,
    output logic [SelW-1:0] sel_o
);
    logic [SelW-1:0] r_ptr, r_sel, w_pick, w_idx;
    logic            r_lock, w_found;
    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = SelW'((int'(r_ptr) + k) % N);
            if (valid_i[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end
    assign req_o = r_lock | (w_found & en_i);
    assign sel_o = r_lock ? r_sel : w_pick;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr  <= '0;
            r_sel  <= '0;
            r_lock <= 1'b0;
        end else if (req_o && ready_i) begin
            r_lock <= 1'b0;
            r_ptr  <= (int'(sel_o) == N - 1) ? '0 : sel_o + 1'b1;
        end else if (req_o) begin
            r_lock <= 1'b1;
            r_sel  <= sel_o;
        end
    end
endmodule

`ifdef AXI_MUX_SPILL_REG_EN
module axi_id_mux_spill #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);
    logic [W-1:0] r_buf [2];
    logic [1:0]   r_cnt;
    logic         r_head, w_push, w_pop;
    assign ready_o = r_cnt != 2'd2;
    assign valid_o = r_cnt != 2'd0;
    assign data_o  = r_buf[r_head];
    assign w_push  = valid_i & ready_o;
    assign w_pop   = valid_o & ready_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_head <= 1'b0;
        end else begin
            if (w_push) r_buf[r_head ^ r_cnt[0]] <= data_i;
            if (w_pop) r_head <= ~r_head;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule
`endif

module axi_id_mux #(
    parameter int NoSlvPorts = 2,
    parameter int IdWidth    = 6,
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int WFifoDepth = 4,
    localparam int SelW      = $clog2(NoSlvPorts),
    localparam int StrbWidth = DataWidth / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NoSlvPorts*IdWidth-1:0]   slv_aw_id_i,
    input  logic [NoSlvPorts*AddrWidth-1:0] slv_aw_addr_i,
    input  logic [NoSlvPorts*8-1:0]         slv_aw_len_i,
    input  logic [NoSlvPorts-1:0]           slv_aw_valid_i,
    output logic [NoSlvPorts-1:0]           slv_aw_ready_o,
    input  logic [NoSlvPorts*DataWidth-1:0] slv_w_data_i,
    input  logic [NoSlvPorts*StrbWidth-1:0] slv_w_strb_i,
    input  logic [NoSlvPorts-1:0]           slv_w_last_i,
    input  logic [NoSlvPorts-1:0]           slv_w_valid_i,
    output logic [NoSlvPorts-1:0]           slv_w_ready_o,
    output logic [NoSlvPorts*IdWidth-1:0]   slv_b_id_o,
    output logic [NoSlvPorts*2-1:0]         slv_b_resp_o,
    output logic [NoSlvPorts-1:0]           slv_b_valid_o,
    input  logic [NoSlvPorts-1:0]           slv_b_ready_i,
    input  logic [NoSlvPorts*IdWidth-1:0]   slv_ar_id_i,
    input  logic [NoSlvPorts*AddrWidth-1:0] slv_ar_addr_i,
    input  logic [NoSlvPorts*8-1:0]         slv_ar_len_i,
    input  logic [NoSlvPorts-1:0]           slv_ar_valid_i,
    output logic [NoSlvPorts-1:0]           slv_ar_ready_o,
    output logic [NoSlvPorts*IdWidth-1:0]   slv_r_id_o,
    output logic [NoSlvPorts*DataWidth-1:0] slv_r_data_o,
    output logic [NoSlvPorts*2-1:0]         slv_r_resp_o,
    output logic [NoSlvPorts-1:0]           slv_r_last_o,
    output logic [NoSlvPorts-1:0]           slv_r_valid_o,
    input  logic [NoSlvPorts-1:0]           slv_r_ready_i,
    output logic [IdWidth-1:0]              mst_aw_id_o,
    output logic [AddrWidth-1:0]            mst_aw_addr_o,
    output logic [7:0]                      mst_aw_len_o,
    output logic                            mst_aw_valid_o,
    input  logic                            mst_aw_ready_i,
    output logic [DataWidth-1:0]            mst_w_data_o,
    output logic [StrbWidth-1:0]            mst_w_strb_o,
    output logic                            mst_w_last_o,
    output logic                            mst_w_valid_o,
    input  logic                            mst_w_ready_i,
    input  logic [IdWidth-1:0]              mst_b_id_i,
    input  logic [1:0]                      mst_b_resp_i,
    input  logic                            mst_b_valid_i,
    output logic                            mst_b_ready_o,
    output logic [IdWidth-1:0]              mst_ar_id_o,
    output logic [AddrWidth-1:0]            mst_ar_addr_o,
    output logic [7:0]                      mst_ar_len_o,
    output logic                            mst_ar_valid_o,
    input  logic                            mst_ar_ready_i,
    input  logic [IdWidth-1:0]              mst_r_id_i,
    input  logic [DataWidth-1:0]            mst_r_data_i,
    input  logic [1:0]                      mst_r_resp_i,
    input  logic                            mst_r_last_i,
    input  logic                            mst_r_valid_i,
    output logic                            mst_r_ready_o
);
    localparam int PtrW = $clog2(WFifoDepth);
    localparam int PlW  = IdWidth + AddrWidth + 8;
    logic [SelW-1:0] w_aw_sel, w_ar_sel, w_ws, w_b_sel, w_r_sel;
    logic            w_aw_req, w_aw_rdy, w_ar_req, w_ar_rdy, w_full, w_empty, w_push, w_pop;
    logic            w_b_ok, w_r_ok;
    logic [PlW-1:0]  w_aw_pl, w_ar_pl;
    logic [SelW-1:0] r_wf [WFifoDepth];
    logic [PtrW-1:0] r_wr, r_rd;
    logic [PtrW:0]   r_cnt;

    axi_id_mux_rr #(.N(NoSlvPorts), .SelW(SelW)) u_aw_rr (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(slv_aw_valid_i), .en_i(!w_full),
        .ready_i(w_aw_rdy), .req_o(w_aw_req), .sel_o(w_aw_sel)
    );
    axi_id_mux_rr #(.N(NoSlvPorts), .SelW(SelW)) u_ar_rr (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(slv_ar_valid_i), .en_i(1'b1),
        .ready_i(w_ar_rdy), .req_o(w_ar_req), .sel_o(w_ar_sel)
    );
    assign w_aw_pl = {slv_aw_id_i[w_aw_sel*IdWidth +: IdWidth],
                      slv_aw_addr_i[w_aw_sel*AddrWidth +: AddrWidth], slv_aw_len_i[w_aw_sel*8 +: 8]};
    assign w_ar_pl = {slv_ar_id_i[w_ar_sel*IdWidth +: IdWidth],
                      slv_ar_addr_i[w_ar_sel*AddrWidth +: AddrWidth], slv_ar_len_i[w_ar_sel*8 +: 8]};
    assign slv_aw_ready_o = w_aw_req ? NoSlvPorts'(w_aw_rdy) << w_aw_sel : '0;
    assign slv_ar_ready_o = w_ar_req ? NoSlvPorts'(w_ar_rdy) << w_ar_sel : '0;
`ifdef AXI_MUX_SPILL_REG_EN
    axi_id_mux_spill #(.W(PlW)) u_aw_spill (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(w_aw_req), .ready_o(w_aw_rdy), .data_i(w_aw_pl),
        .valid_o(mst_aw_valid_o), .ready_i(mst_aw_ready_i), .data_o({mst_aw_id_o, mst_aw_addr_o, mst_aw_len_o})
    );
    axi_id_mux_spill #(.W(PlW)) u_ar_spill (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(w_ar_req), .ready_o(w_ar_rdy), .data_i(w_ar_pl),
        .valid_o(mst_ar_valid_o), .ready_i(mst_ar_ready_i), .data_o({mst_ar_id_o, mst_ar_addr_o, mst_ar_len_o})
    );
`else
    assign w_aw_rdy       = mst_aw_ready_i;
    assign w_ar_rdy       = mst_ar_ready_i;
    assign mst_aw_valid_o = w_aw_req;
    assign mst_ar_valid_o = w_ar_req;
    assign {mst_aw_id_o, mst_aw_addr_o, mst_aw_len_o} = w_aw_pl;
    assign {mst_ar_id_o, mst_ar_addr_o, mst_ar_len_o} = w_ar_pl;
`endif

    // W-order FIFO: one entry per accepted AW, popped on the matching W-last.
    assign w_full  = r_cnt == (PtrW + 1)'(WFifoDepth);
    assign w_empty = r_cnt == '0;
    assign w_ws    = r_wf[r_rd];
    assign w_push  = w_aw_req & w_aw_rdy;
    assign w_pop   = mst_w_valid_o & mst_w_ready_i & mst_w_last_o;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wf[r_wr] <= w_aw_sel;
                r_wr       <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (PtrW + 1)'(w_push) - (PtrW + 1)'(w_pop);
        end
    end
    assign mst_w_valid_o = !w_empty & slv_w_valid_i[w_ws];
    assign mst_w_data_o  = slv_w_data_i[w_ws*DataWidth +: DataWidth];
    assign mst_w_strb_o  = slv_w_strb_i[w_ws*StrbWidth +: StrbWidth];
    assign mst_w_last_o  = slv_w_last_i[w_ws];
    assign slv_w_ready_o = w_empty ? '0 : NoSlvPorts'(mst_w_ready_i) << w_ws;

    // Responses whose prepended port index is out of range are sunk.
    assign w_b_sel       = mst_b_id_i[IdWidth-1 -: SelW];
    assign w_r_sel       = mst_r_id_i[IdWidth-1 -: SelW];
    assign w_b_ok        = int'(w_b_sel) < NoSlvPorts;
    assign w_r_ok        = int'(w_r_sel) < NoSlvPorts;
    assign slv_b_valid_o = w_b_ok ? NoSlvPorts'(mst_b_valid_i) << w_b_sel : '0;
    assign slv_r_valid_o = w_r_ok ? NoSlvPorts'(mst_r_valid_i) << w_r_sel : '0;
    assign mst_b_ready_o = w_b_ok ? slv_b_ready_i[w_b_sel] : 1'b1;
    assign mst_r_ready_o = w_r_ok ? slv_r_ready_i[w_r_sel] : 1'b1;
    assign slv_b_id_o    = {NoSlvPorts{mst_b_id_i}};
    assign slv_b_resp_o  = {NoSlvPorts{mst_b_resp_i}};
    assign slv_r_id_o    = {NoSlvPorts{mst_r_id_i}};
    assign slv_r_data_o  = {NoSlvPorts{mst_r_data_i}};
    assign slv_r_resp_o  = {NoSlvPorts{mst_r_resp_i}};
    assign slv_r_last_o  = {NoSlvPorts{mst_r_last_i}};
endmodule

// File: tb/tb_axi_id_mux.sv
// tb_axi_id_mux: table-driven B/R routing checks plus AW/W scoreboarded sequences.
// A second three-port instance covers out-of-range response IDs.
module tb_axi_id_mux;
    localparam int N = 2, N3 = 3, IW = 6, AW = 32, DW = 32, SW = 4;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*IW-1:0] slv_aw_id, slv_ar_id, slv_b_id, slv_r_id;
    logic [N*AW-1:0] slv_aw_addr, slv_ar_addr;
    logic [N*8-1:0]  slv_aw_len, slv_ar_len;
    logic [N-1:0]    slv_aw_valid, slv_aw_ready, slv_ar_valid, slv_ar_ready;
    logic [N*DW-1:0] slv_w_data, slv_r_data;
    logic [N*SW-1:0] slv_w_strb;
    logic [N-1:0]    slv_w_last, slv_w_valid, slv_w_ready, slv_b_valid, slv_b_ready;
    logic [N*2-1:0]  slv_b_resp, slv_r_resp;
    logic [N-1:0]    slv_r_last, slv_r_valid, slv_r_ready;
    logic [IW-1:0]   mst_aw_id, mst_ar_id, mst_b_id, mst_r_id;
    logic [AW-1:0]   mst_aw_addr, mst_ar_addr;
    logic [7:0]      mst_aw_len, mst_ar_len;
    logic            mst_aw_valid, mst_aw_ready, mst_ar_valid, mst_ar_ready;
    logic [DW-1:0]   mst_w_data, mst_r_data;
    logic [SW-1:0]   mst_w_strb;
    logic            mst_w_last, mst_w_valid, mst_w_ready;
    logic [1:0]      mst_b_resp, mst_r_resp;
    logic            mst_b_valid, mst_b_ready, mst_r_last, mst_r_valid, mst_r_ready;

    logic [N3-1:0]    t_slv_aw_ready, t_slv_w_ready, t_slv_ar_ready, t_slv_b_valid, t_slv_r_valid, t_slv_r_last;
    logic [N3*IW-1:0] t_slv_b_id, t_slv_r_id;
    logic [N3*2-1:0]  t_slv_b_resp, t_slv_r_resp;
    logic [N3*DW-1:0] t_slv_r_data;
    logic [N3-1:0]    t_slv_b_ready, t_slv_r_ready;
    logic [IW-1:0]    t_mst_aw_id, t_mst_ar_id, t_mst_b_id, t_mst_r_id;
    logic [AW-1:0]    t_mst_aw_addr, t_mst_ar_addr;
    logic [7:0]       t_mst_aw_len, t_mst_ar_len;
    logic [DW-1:0]    t_mst_w_data;
    logic [SW-1:0]    t_mst_w_strb;
    logic             t_mst_aw_valid, t_mst_ar_valid, t_mst_w_last, t_mst_w_valid;
    logic             t_mst_b_valid, t_mst_b_ready, t_mst_r_valid, t_mst_r_ready;

    axi_id_mux dut (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_id_i(slv_aw_id), .slv_aw_addr_i(slv_aw_addr), .slv_aw_len_i(slv_aw_len),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
        .slv_w_data_i(slv_w_data), .slv_w_strb_i(slv_w_strb), .slv_w_last_i(slv_w_last),
        .slv_w_valid_i(slv_w_valid), .slv_w_ready_o(slv_w_ready),
        .slv_b_id_o(slv_b_id), .slv_b_resp_o(slv_b_resp), .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(slv_b_ready),
        .slv_ar_id_i(slv_ar_id), .slv_ar_addr_i(slv_ar_addr), .slv_ar_len_i(slv_ar_len),
        .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready),
        .slv_r_id_o(slv_r_id), .slv_r_data_o(slv_r_data), .slv_r_resp_o(slv_r_resp), .slv_r_last_o(slv_r_last),
        .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(slv_r_ready),
        .mst_aw_id_o(mst_aw_id), .mst_aw_addr_o(mst_aw_addr), .mst_aw_len_o(mst_aw_len),
        .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
        .mst_w_data_o(mst_w_data), .mst_w_strb_o(mst_w_strb), .mst_w_last_o(mst_w_last),
        .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready),
        .mst_b_id_i(mst_b_id), .mst_b_resp_i(mst_b_resp), .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready),
        .mst_ar_id_o(mst_ar_id), .mst_ar_addr_o(mst_ar_addr), .mst_ar_len_o(mst_ar_len),
        .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
        .mst_r_id_i(mst_r_id), .mst_r_data_i(mst_r_data), .mst_r_resp_i(mst_r_resp), .mst_r_last_i(mst_r_last),
        .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready)
    );

    axi_id_mux #(.NoSlvPorts(N3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_id_i('0), .slv_aw_addr_i('0), .slv_aw_len_i('0),
        .slv_aw_valid_i('0), .slv_aw_ready_o(t_slv_aw_ready),
        .slv_w_data_i('0), .slv_w_strb_i('0), .slv_w_last_i('0),
        .slv_w_valid_i('0), .slv_w_ready_o(t_slv_w_ready),
        .slv_b_id_o(t_slv_b_id), .slv_b_resp_o(t_slv_b_resp), .slv_b_valid_o(t_slv_b_valid), .slv_b_ready_i(t_slv_b_ready),
        .slv_ar_id_i('0), .slv_ar_addr_i('0), .slv_ar_len_i('0),
        .slv_ar_valid_i('0), .slv_ar_ready_o(t_slv_ar_ready),
        .slv_r_id_o(t_slv_r_id), .slv_r_data_o(t_slv_r_data), .slv_r_resp_o(t_slv_r_resp), .slv_r_last_o(t_slv_r_last),
        .slv_r_valid_o(t_slv_r_valid), .slv_r_ready_i(t_slv_r_ready),
        .mst_aw_id_o(t_mst_aw_id), .mst_aw_addr_o(t_mst_aw_addr), .mst_aw_len_o(t_mst_aw_len),
        .mst_aw_valid_o(t_mst_aw_valid), .mst_aw_ready_i(1'b1),
        .mst_w_data_o(t_mst_w_data), .mst_w_strb_o(t_mst_w_strb), .mst_w_last_o(t_mst_w_last),
        .mst_w_valid_o(t_mst_w_valid), .mst_w_ready_i(1'b1),
        .mst_b_id_i(t_mst_b_id), .mst_b_resp_i(2'b00), .mst_b_valid_i(t_mst_b_valid), .mst_b_ready_o(t_mst_b_ready),
        .mst_ar_id_o(t_mst_ar_id), .mst_ar_addr_o(t_mst_ar_addr), .mst_ar_len_o(t_mst_ar_len),
        .mst_ar_valid_o(t_mst_ar_valid), .mst_ar_ready_i(1'b1),
        .mst_r_id_i(t_mst_r_id), .mst_r_data_i('0), .mst_r_resp_i(2'b00), .mst_r_last_i(1'b0),
        .mst_r_valid_i(t_mst_r_valid), .mst_r_ready_o(t_mst_r_ready)
    );

    int n_cmp = 0, n_err = 0;
    logic [IW-1:0] aq[$];
    logic [DW-1:0] wq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && mst_aw_valid && mst_aw_ready) begin
            if (aq.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
            else chk("aw_id_sb", 64'(mst_aw_id), 64'(aq.pop_front()));
        end
        if (!rst && mst_w_valid && mst_w_ready) begin
            if (wq.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
            else chk("w_data_sb", 64'(mst_w_data), 64'(wq.pop_front()));
        end
    end

    typedef struct {
        bit         big;
        logic [5:0] id;
        logic       vld;
        logic [2:0] rdy;
        logic [2:0] ev;
        logic       er;
    } rt_t;
    rt_t tv [8];

    logic [5:0] r_ids [5];
    logic       r_lasts [5];

    initial begin
        tv[0] = '{1'b0, 6'h2A, 1'b1, 3'b000, 3'b010, 1'b0};
        tv[1] = '{1'b0, 6'h2A, 1'b1, 3'b010, 3'b010, 1'b1};
        tv[2] = '{1'b0, 6'h05, 1'b1, 3'b001, 3'b001, 1'b1};
        tv[3] = '{1'b0, 6'h05, 1'b0, 3'b011, 3'b000, 1'b1};
        tv[4] = '{1'b1, 6'h3F, 1'b1, 3'b000, 3'b000, 1'b1};
        tv[5] = '{1'b1, 6'h25, 1'b1, 3'b100, 3'b100, 1'b1};
        tv[6] = '{1'b1, 6'h25, 1'b1, 3'b011, 3'b100, 1'b0};
        tv[7] = '{1'b1, 6'h13, 1'b1, 3'b010, 3'b010, 1'b1};
        r_ids   = '{6'h13, 6'h21, 6'h13, 6'h13, 6'h21};
        r_lasts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        slv_aw_id = '0; slv_aw_addr = '0; slv_aw_len = '0; slv_aw_valid = '0;
        slv_ar_id = '0; slv_ar_addr = '0; slv_ar_len = '0; slv_ar_valid = '0;
        slv_w_data = '0; slv_w_strb = '1; slv_w_last = '0; slv_w_valid = '0;
        slv_b_ready = '0; slv_r_ready = '0;
        mst_aw_ready = 1'b1; mst_ar_ready = 1'b1; mst_w_ready = 1'b1;
        mst_b_id = '0; mst_b_resp = '0; mst_b_valid = 1'b0;
        mst_r_id = '0; mst_r_data = '0; mst_r_resp = '0; mst_r_last = 1'b0; mst_r_valid = 1'b0;
        t_mst_b_id = '0; t_mst_b_valid = 1'b0; t_slv_b_ready = '0;
        t_mst_r_id = '0; t_mst_r_valid = 1'b0; t_slv_r_ready = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state: nothing granted, W FIFO empty even with W valid offered.
        slv_w_valid = 2'b11;
        settle();
        chk("rst_mst_aw_valid", 64'(mst_aw_valid), 64'd0);
        chk("rst_mst_ar_valid", 64'(mst_ar_valid), 64'd0);
        chk("rst_mst_w_valid", 64'(mst_w_valid), 64'd0);
        chk("rst_slv_w_ready", 64'(slv_w_ready), 64'd0);
        chk("rst_slv_b_valid", 64'(slv_b_valid), 64'd0);
        chk("rst_slv_r_valid", 64'(slv_r_valid), 64'd0);
        tick();

        // Single AW from p0 plus a 4-beat W burst.
        slv_aw_id[5:0] = 6'h05; slv_aw_addr[31:0] = 32'h100; slv_aw_len[7:0] = 8'd3; slv_aw_valid = 2'b01;
        slv_w_valid = 2'b01; slv_w_data[31:0] = 32'hD0; slv_w_last = 2'b00;
        aq.push_back(6'h05);
        settle();
        chk("aw_valid", 64'(mst_aw_valid), 64'd1);
        chk("aw_id", 64'(mst_aw_id), 64'h05);
        chk("aw_addr", 64'(mst_aw_addr), 64'h100);
        chk("aw_len", 64'(mst_aw_len), 64'd3);
        chk("aw_ready_p0", 64'(slv_aw_ready), 64'b01);
        chk("w_before_aw", 64'(mst_w_valid), 64'd0);
        chk("w_ready_before_aw", 64'(slv_w_ready), 64'd0);
        tick();
        slv_aw_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            slv_w_data[31:0] = 32'hD0 + 32'(i);
            slv_w_last[0] = (i == 3);
            wq.push_back(32'hD0 + 32'(i));
            settle();
            chk("w_ready_p0", 64'(slv_w_ready), 64'b01);
            chk("w_last", 64'(mst_w_last), 64'(i == 3));
            tick();
        end
        slv_w_data[31:0] = 32'hD4; slv_w_last = 2'b00;
        settle();
        chk("w_fifo_empty", 64'(mst_w_valid), 64'd0);
        tick();
        slv_w_valid = 2'b00;

        // Alternating grants, then lock held while master stalls.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        slv_aw_id = {6'h2B, 6'h0A}; slv_aw_addr = {32'h2000, 32'h1000}; slv_aw_len = '0;
        slv_aw_valid = 2'b11; mst_w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            aq.push_back(i % 2 == 1 ? 6'h2B : 6'h0A);
            settle();
            chk("rr_grant", 64'(slv_aw_ready), i % 2 == 1 ? 64'b10 : 64'b01);
            tick();
        end
        mst_aw_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lock_id", 64'(mst_aw_id), 64'h2B);
            chk("lock_valid", 64'(mst_aw_valid), 64'd1);
            chk("lock_ready", 64'(slv_aw_ready), 64'b00);
            tick();
        end
        mst_aw_ready = 1'b1;
        aq.push_back(6'h2B);
        settle();
        chk("lock_release", 64'(slv_aw_ready), 64'b10);
        tick();

        // W FIFO full: fifth AW stalls until a W-last is accepted.
        slv_aw_valid = 2'b01;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("full_aw_valid", 64'(mst_aw_valid), 64'd0);
            chk("full_aw_ready", 64'(slv_aw_ready), 64'b00);
            tick();
        end
        mst_w_ready = 1'b1; slv_w_valid = 2'b01; slv_w_data[31:0] = 32'hE0; slv_w_last = 2'b11;
        wq.push_back(32'hE0);
        settle();
        chk("full_w_ready", 64'(slv_w_ready), 64'b01);
        chk("full_same_cycle_pop", 64'(mst_aw_valid), 64'd0);
        tick();
        slv_w_valid = 2'b00;
        aq.push_back(6'h0A);
        settle();
        chk("full_freed", 64'(slv_aw_ready), 64'b01);
        tick();
        slv_aw_valid = 2'b00;
        slv_w_data = {32'hF1, 32'hF0}; slv_w_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wq.push_back(i % 2 == 0 ? 32'hF1 : 32'hF0);
            settle();
            chk("w_order", 64'(slv_w_ready), i % 2 == 0 ? 64'b10 : 64'b01);
            tick();
        end
        settle();
        chk("w_drained", 64'(mst_w_valid), 64'd0);
        tick();
        slv_w_valid = 2'b00; slv_w_last = 2'b00;

        // B/R routing table (main: N=2, big: N=3).
        for (int i = 0; i < 8; i++) begin
            if (tv[i].big) begin
                t_mst_b_id = tv[i].id; t_mst_b_valid = tv[i].vld; t_slv_b_ready = tv[i].rdy;
                t_mst_r_id = tv[i].id; t_mst_r_valid = tv[i].vld; t_slv_r_ready = tv[i].rdy;
                settle();
                chk($sformatf("b3_valid[%0d]", i), 64'(t_slv_b_valid), 64'(tv[i].ev));
                chk($sformatf("b3_ready[%0d]", i), 64'(t_mst_b_ready), 64'(tv[i].er));
                chk($sformatf("r3_valid[%0d]", i), 64'(t_slv_r_valid), 64'(tv[i].ev));
                chk($sformatf("r3_ready[%0d]", i), 64'(t_mst_r_ready), 64'(tv[i].er));
            end else begin
                mst_b_id = tv[i].id; mst_b_valid = tv[i].vld; slv_b_ready = tv[i].rdy[1:0];
                mst_r_id = tv[i].id; mst_r_valid = tv[i].vld; slv_r_ready = tv[i].rdy[1:0];
                settle();
                chk($sformatf("b_valid[%0d]", i), 64'(slv_b_valid), 64'(tv[i].ev[1:0]));
                chk($sformatf("b_ready[%0d]", i), 64'(mst_b_ready), 64'(tv[i].er));
                chk($sformatf("r_valid[%0d]", i), 64'(slv_r_valid), 64'(tv[i].ev[1:0]));
                chk($sformatf("r_ready[%0d]", i), 64'(mst_r_ready), 64'(tv[i].er));
                chk($sformatf("b_bcast[%0d]", i), 64'(slv_b_id), 64'({2{tv[i].id}}));
            end
            tick();
        end
        mst_b_valid = 1'b0; t_mst_b_valid = 1'b0; t_mst_r_valid = 1'b0;

        // Interleaved R bursts id 0x13 (port 0) and 0x21 (port 1).
        slv_r_ready = 2'b11; mst_r_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            int p;
            p = r_ids[j][5] ? 1 : 0;
            mst_r_id = r_ids[j]; mst_r_data = 32'hA0 + 32'(j); mst_r_last = r_lasts[j];
            settle();
            chk("r_il_valid", 64'(slv_r_valid), p == 1 ? 64'b10 : 64'b01);
            chk("r_il_last", 64'(slv_r_last[p]), 64'(r_lasts[j]));
            chk("r_il_data", 64'(slv_r_data[p*DW +: DW]), 64'(32'hA0 + 32'(j)));
            chk("r_il_ready", 64'(mst_r_ready), 64'd1);
            tick();
        end
        mst_r_valid = 1'b0;

        // Reset in the middle of a W burst.
        slv_aw_len[7:0] = 8'd3; slv_aw_valid = 2'b01;
        aq.push_back(6'h0A);
        settle();
        tick();
        slv_aw_valid = 2'b00; slv_w_valid = 2'b01; slv_w_last = 2'b00;
        for (int i = 0; i < 2; i++) begin
            slv_w_data[31:0] = 32'hC0 + 32'(i);
            wq.push_back(32'hC0 + 32'(i));
            settle();
            chk("mid_w_ready", 64'(slv_w_ready), 64'b01);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        slv_w_valid = 2'b11; slv_aw_valid = 2'b11;
        aq.push_back(6'h0A);
        settle();
        chk("post_rst_w_valid", 64'(mst_w_valid), 64'd0);
        chk("post_rst_w_ready", 64'(slv_w_ready), 64'b00);
        chk("post_rst_ptr", 64'(slv_aw_ready), 64'b01);
        chk("post_rst_ar_valid", 64'(mst_ar_valid), 64'd0);
        tick();
        slv_aw_valid = 2'b00; slv_w_valid = 2'b00;
        repeat (2) tick();
        chk("aw_sb_drained", 64'(aq.size()), 64'd0);
        chk("w_sb_drained", 64'(wq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
